// File: rtl/demux8_deserializer.sv
// Serial-to-parallel receiver for an 8-slot select-driven link: slot k of each
// frame lands on dout[k], with abort detection and an exported slot index.
module demux8_deserializer #(
  parameter logic [7:0] IDLE_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       start,
  output logic [7:0] dout,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [2:0] slot,
  output logic       busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] shreg;

  // NOTE: every register here uses non-blocking assignment so that all
  // right-hand sides see pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= 3'd0;
      shreg       <= 8'h00;
      dout        <= IDLE_VAL;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (din_valid && start) begin
            shreg <= {7'b0, din};
            slot  <= 3'd1;
            state <= COLLECT;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (din_valid) begin
            if (start) begin
              // A restart beats completion even at slot 7.
              frame_err <= 1'b1;
              shreg     <= {7'b0, din};
              slot      <= 3'd1;
            end else if (slot == 3'd7) begin
              shreg[7]    <= din;
              dout        <= {din, shreg[6:0]};
              frame_valid <= 1'b1;
              slot        <= 3'd0;
              state       <= IDLE;
              busy        <= 1'b0;
            end else begin
              shreg[slot] <= din;
              slot        <= slot + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          slot  <= 3'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
